// File: rtl/minigame_sequencer_pkg.sv
// Shared definitions for the minigame session sequencer.
//   - estado_t      : FSM state codes, also exported on the estado port
//   - MODO_*        : play mode codes sampled from the modo input
//   - INTERVAL_DEFAULT : default pause before each game start, in cycles
//   - cnt_width()   : register width for a down-counter that starts at M-1
package minigame_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_INICIAL    = 3'd0,
      ST_PREPARACAO = 3'd1,
      ST_INTERVALO  = 3'd2,
      ST_START      = 3'd3,
      ST_EXECUCAO   = 3'd4,
      ST_ACUMULA    = 3'd5,
      ST_FIM        = 3'd6
   } estado_t;

   localparam logic MODO_SINGLE   = 1'b0;
   localparam logic MODO_MARATONA = 1'b1;

   localparam int INTERVAL_DEFAULT = 2000;

   // A counter loaded with M-1 needs at least one bit even when M is 1.
   function automatic int cnt_width(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/minigame_sequencer_contador_m.sv
// contador_m: cycle timer for the sequencer.
// Down-counter with terminal-count flag. zera_s restarts the period (loads
// M-1), conta advances one step, fim is high on the M-th cycle counted after
// a restart. The counter parks at zero instead of wrapping.
// Ports:
//   clock    in  system clock
//   reset_in in  asynchronous active-low reset
//   zera_s   in  synchronous restart, has priority over conta
//   conta    in  count enable
//   fim      out terminal count reached
module contador_m
   import minigame_sequencer_pkg::*;
#(
   parameter int M = 4
) (
   input  logic clock,
   input  logic reset_in,
   input  logic zera_s,
   input  logic conta,
   output logic fim
);

   localparam int            W    = cnt_width(M);
   localparam logic [W-1:0]  LOAD = W'(M - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clock or negedge reset_in) begin
      if (!reset_in) begin
         cnt_q <= '0;
      end else if (zera_s) begin
         cnt_q <= LOAD;
      end else if (conta && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign fim = (cnt_q == '0);

endmodule

// File: rtl/minigame_sequencer.sv
// minigame_sequencer: session controller for N_GAMES attached minigames.
// Starts the chosen game with a one-cycle pulse after a fixed pause, waits for
// the rising edge of its pronto line (optionally bounded by a timeout), adds
// its score to a saturating session total and, in marathon mode, walks
// through every game in index order.
//
// state       | meaning
// ------------+------------------------------------------------------------
// INICIAL     | idle after reset, waiting for iniciar
// PREPARACAO  | latch mode/difficulty/game, clear session; wait valid game
// INTERVALO   | pause of INTERVAL cycles before the start pulse
// START       | one-cycle jogar pulse to the active game
// EXECUCAO    | wait for pronto rising edge or timeout
// ACUMULA     | add round score, advance round/game
// FIM         | session over, results held until iniciar
//
// Ports:
//   clock, reset_in        clock and async active-low reset
//   iniciar                start/restart request
//   modo                   0 single game, 1 marathon
//   dificuldade            difficulty switch, latched per session
//   minigame               game index for single mode
//   pronto_vec             per-game completion levels
//   pontuacao_flat         per-game scores, game k at [k*SCORE_W +: SCORE_W]
//   jogar_vec              one-hot start pulse
//   game_sel               active game index
//   dificuldade_lat        latched difficulty
//   estado                 FSM state code
//   pontuacao_total        saturating session score
//   rodada                 rounds completed this session
//   fim_sessao             high in FIM
//   timeout                sticky, some round of this session timed out
module minigame_sequencer
   import minigame_sequencer_pkg::*;
#(
   parameter int N_GAMES     = 3,
   parameter int GAME_W      = 2,
   parameter int INTERVAL    = INTERVAL_DEFAULT,
   parameter int TIMEOUT_CYC = 0,
   parameter int SCORE_W     = 3,
   parameter int ACC_W       = 8
) (
   input  logic                         clock,
   input  logic                         reset_in,
   input  logic                         iniciar,
   input  logic                         modo,
   input  logic                         dificuldade,
   input  logic [GAME_W-1:0]            minigame,
   input  logic [N_GAMES-1:0]           pronto_vec,
   input  logic [N_GAMES*SCORE_W-1:0]   pontuacao_flat,
   output logic [N_GAMES-1:0]           jogar_vec,
   output logic [GAME_W-1:0]            game_sel,
   output logic                         dificuldade_lat,
   output logic [2:0]                   estado,
   output logic [ACC_W-1:0]             pontuacao_total,
   output logic [GAME_W-1:0]            rodada,
   output logic                         fim_sessao,
   output logic                         timeout
);

   localparam logic [GAME_W-1:0] N_GAMES_G = GAME_W'(N_GAMES);
   localparam logic [GAME_W-1:0] LAST_GAME = GAME_W'(N_GAMES - 1);

   estado_t              state_q, state_d;
   logic                 modo_q;
   logic                 dif_q;
   logic [GAME_W-1:0]    game_sel_q;
   logic [ACC_W-1:0]     total_q;
   logic [GAME_W-1:0]    rodada_q;
   logic                 timeout_q;
   logic                 round_to_q;
   logic                 pronto_q;

   logic                 pronto_sel;
   logic [SCORE_W-1:0]   score_sel;
   logic                 done_edge;
   logic                 intv_zera;
   logic                 intv_fim;
   logic                 tmo_fim;
   logic                 more_games;
   logic [ACC_W-1:0]     add_val;
   logic [ACC_W:0]       sum_ext;
   logic [ACC_W-1:0]     total_sat;

   // Pick the active game's pronto line and score; an out-of-range index
   // selects nothing.
   always_comb begin
      pronto_sel = 1'b0;
      score_sel  = '0;
      for (int k = 0; k < N_GAMES; k++) begin
         if (game_sel_q == GAME_W'(k)) begin
            pronto_sel = pronto_vec[k];
            score_sel  = pontuacao_flat[k*SCORE_W +: SCORE_W];
         end
      end
   end

   // pronto_q tracks the active line every cycle, so by EXECUCAO it holds the
   // level seen in START; a level left high by an earlier round never counts.
   assign done_edge  = pronto_sel & ~pronto_q;
   assign more_games = (modo_q == MODO_MARATONA) && (game_sel_q < LAST_GAME);

   assign add_val   = round_to_q ? '0 : ACC_W'(score_sel);
   assign sum_ext   = {1'b0, total_q} + {1'b0, add_val};
   assign total_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];

   assign intv_zera = (state_d == ST_INTERVALO) && (state_q != ST_INTERVALO);

   contador_m #(.M(INTERVAL)) u_intervalo (
      .clock    (clock),
      .reset_in (reset_in),
      .zera_s   (intv_zera),
      .conta    (state_q == ST_INTERVALO),
      .fim      (intv_fim)
   );

   generate
      if (TIMEOUT_CYC > 0) begin : g_timeout
         contador_m #(.M(TIMEOUT_CYC)) u_timeout (
            .clock    (clock),
            .reset_in (reset_in),
            .zera_s   (state_q == ST_START),
            .conta    (state_q == ST_EXECUCAO),
            .fim      (tmo_fim)
         );
      end else begin : g_no_timeout
         assign tmo_fim = 1'b0;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_in) begin
      if (!reset_in) begin
         state_q <= ST_INICIAL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INICIAL: begin
            if (iniciar) state_d = ST_PREPARACAO;
         end
         ST_PREPARACAO: begin
            if ((modo == MODO_MARATONA) || (minigame < N_GAMES_G))
               state_d = ST_INTERVALO;
         end
         ST_INTERVALO: begin
            if (intv_fim) state_d = ST_START;
         end
         ST_START: begin
            state_d = ST_EXECUCAO;
         end
         ST_EXECUCAO: begin
            if (done_edge || tmo_fim) state_d = ST_ACUMULA;
         end
         ST_ACUMULA: begin
            state_d = more_games ? ST_INTERVALO : ST_FIM;
         end
         ST_FIM: begin
            if (iniciar) state_d = ST_PREPARACAO;
         end
         default: begin
            state_d = ST_INICIAL;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_in) begin
      if (!reset_in) begin
         modo_q     <= MODO_SINGLE;
         dif_q      <= 1'b0;
         game_sel_q <= '0;
         total_q    <= '0;
         rodada_q   <= '0;
         timeout_q  <= 1'b0;
         round_to_q <= 1'b0;
         pronto_q   <= 1'b0;
      end else begin
         pronto_q <= pronto_sel;
         case (state_q)
            ST_PREPARACAO: begin
               modo_q     <= modo;
               dif_q      <= dificuldade;
               game_sel_q <= (modo == MODO_MARATONA) ? '0 : minigame;
               total_q    <= '0;
               rodada_q   <= '0;
               timeout_q  <= 1'b0;
            end
            ST_START: begin
               round_to_q <= 1'b0;
            end
            ST_EXECUCAO: begin
               // A completion in the same cycle as the timeout still scores.
               if (!done_edge && tmo_fim) begin
                  timeout_q  <= 1'b1;
                  round_to_q <= 1'b1;
               end
            end
            ST_ACUMULA: begin
               total_q  <= total_sat;
               rodada_q <= rodada_q + GAME_W'(1);
               if (more_games) game_sel_q <= game_sel_q + GAME_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Decoded from the state register, so reset clears the pulse immediately.
   always_comb begin
      jogar_vec = '0;
      if (state_q == ST_START) begin
         for (int k = 0; k < N_GAMES; k++) begin
            jogar_vec[k] = (game_sel_q == GAME_W'(k));
         end
      end
   end

   assign game_sel        = game_sel_q;
   assign dificuldade_lat = dif_q;
   assign estado          = state_q;
   assign pontuacao_total = total_q;
   assign rodada          = rodada_q;
   assign fim_sessao      = (state_q == ST_FIM);
   assign timeout         = timeout_q;

endmodule

// File: doc/minigame_sequencer.md
Name: minigame_sequencer

Overview:
Parametrised session controller that sequences N minigames.
- Drives a one-cycle start pulse to the selected game.
- Waits for the game's completion, with an optional timeout.
- Accumulates scores across rounds.
- Adds a marathon mode that plays every game in order.
- Sits between the debounced inputs and the minigame instances; its outputs feed the output mux, the displays and serial TX.

Parameters:
N_GAMES, 3, number of attached minigames (>=2)
GAME_W, 2, width of game index, must satisfy 2^GAME_W > N_GAMES
INTERVAL, 2000, cycles spent in INTERVALO before each start (>=1)
TIMEOUT_CYC, 0, max cycles in EXECUCAO; 0 disables the timeout
SCORE_W, 3, per-game score width
ACC_W, 8, accumulated session score width

Ports:
clock  in  1  system clock (divided game clock)
reset_in  in  1  asynchronous, active-low reset
iniciar  in  1  start/restart request, active-high, already synchronised
modo  in  1  0 = single game, 1 = marathon
dificuldade  in  1  difficulty switch
minigame  in  GAME_W  selected game in single mode
pronto_vec  in  N_GAMES  per-game completion level
pontuacao_flat  in  N_GAMES*SCORE_W  per-game scores; game k occupies bits [k*SCORE_W +: SCORE_W]
jogar_vec  out  N_GAMES  one-hot, one-cycle start pulse
game_sel  out  GAME_W  active game index, drives output mux
dificuldade_lat  out  1  difficulty latched for the session
estado  out  3  FSM state code
pontuacao_total  out  ACC_W  saturating session score
rodada  out  GAME_W  rounds completed in current session
fim_sessao  out  1  high while in FIM
timeout  out  1  sticky: some round in this session timed out

Behaviour:
- Reset (reset_in=0, async): estado=INICIAL, every output and internal register 0.
- State codes: INICIAL=0, PREPARACAO=1, INTERVALO=2, START=3, EXECUCAO=4, ACUMULA=5, FIM=6. Code 7 is illegal and goes to INICIAL.
- INICIAL: iniciar=1 -> PREPARACAO next cycle.
- PREPARACAO:
  - Every cycle latches modo, dificuldade_lat, and game_sel (minigame if modo=0, else 0).
  - Clears pontuacao_total, rodada and timeout.
  - Exit to INTERVALO when modo=1, or when modo=0 and minigame<N_GAMES.
  - Otherwise stays; an out-of-range index means "no game chosen".
- INTERVALO: interval counter is zeroed on entry; the state lasts exactly INTERVAL cycles, then START.
- START: lasts 1 cycle; jogar_vec[game_sel]=1, all other bits 0; then EXECUCAO. Timeout counter is zeroed.
- EXECUCAO:
  - Completion is the rising edge of pronto_vec[game_sel] (registered copy of the previous cycle), so a stale high level from the prior round is never taken as completion.
  - The edge-detect register is reloaded in START.
  - pronto bits of non-selected games are ignored.
  - If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC without completion: timeout<=1 and the round scores 0.
  - Either event -> ACUMULA. Completion and timeout in the same cycle: completion wins.
- ACUMULA: lasts 1 cycle.
  - pontuacao_total += selected score (0 on timeout), zero-extended, saturating at 2^ACC_W-1.
  - rodada += 1.
  - If modo=1 and game_sel<N_GAMES-1: game_sel+1 -> INTERVALO. Otherwise -> FIM.
- FIM: fim_sessao=1; outputs hold; iniciar=1 -> PREPARACAO.
- iniciar is ignored in INTERVALO, START, EXECUCAO and ACUMULA. No mid-game abort; only reset_in aborts.
- reset_in asserted mid-session: immediate return to INICIAL, jogar_vec forced 0 asynchronously.
- Latency, single mode, valid selection from INICIAL:
  - iniciar sampled at cycle t; PREPARACAO at t+1; INTERVALO t+2..t+1+INTERVAL.
  - jogar pulse at t+2+INTERVAL.
  - ACUMULA the cycle after the detected pronto edge; FIM the cycle after that.

Decomposition:
- Shared package: state codes, mode codes (MODO_SINGLE=0, MODO_MARATONA=1), default INTERVAL.
- Sub-module: existing contador_m, instantiated twice.
  - Interval counter: M=INTERVAL.
  - Timeout counter: M=TIMEOUT_CYC, generated only when TIMEOUT_CYC>0.
  - Both cleared via zera_s on state entry.
- Score selection from pontuacao_flat and the one-hot pulse are in-module indexed part-selects; no extra module.

Test Plan:
Bench setup: N_GAMES=3, INTERVAL=4, TIMEOUT_CYC=16, SCORE_W=3, ACC_W=6.
1. Single mode, minigame=1, iniciar pulse; pronto_vec[1] rises 10 cycles after jogar with score 5 -> jogar_vec=3'b010 exactly 6 cycles after iniciar, once; pontuacao_total=5, rodada=1, fim_sessao=1.
2. Single mode, minigame=3 (invalid) -> stays in PREPARACAO (estado=1), jogar_vec never asserted; switching to minigame=2 -> INTERVALO next cycle.
3. Marathon, scores 7,7,7 -> jogar pulses 3'b001, 3'b010, 3'b100 in order, each preceded by 4 INTERVALO cycles; pontuacao_total=21, rodada=3, FIM.
4. Marathon, game 1 never asserts pronto -> timeout=1 after 16 EXECUCAO cycles; round adds 0; game 2 still starts; final total = score0 + score2.
5. pronto_vec[0] held high from the previous session, single mode game 0 replayed -> no completion until pronto falls and rises again.
6. Assert reset_in=0 during EXECUCAO -> estado=0, jogar_vec=0, pontuacao_total=0 immediately; iniciar in FIM -> total and timeout cleared in PREPARACAO.
